// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants and filter state encoding for key_debounce
package key_pkg;

  localparam int CLK_PER_MS = 50000;

  typedef logic [1:0] key_state_t;

  localparam key_state_t ST_UP      = 2'd0;
  localparam key_state_t ST_WAIT_DN = 2'd1;
  localparam key_state_t ST_DN      = 2'd2;
  localparam key_state_t ST_WAIT_UP = 2'd3;

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - single key channel: synchroniser, debounce filter, level/pulse/toggle outputs
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_toggle
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             RELEASED = KEY_ACTIVE_LOW;

  logic             r_sync0;
  logic             r_sync1;
  key_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_toggle;

  logic             w_pressed;
  logic             w_cnt_done;
  key_state_t       w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_accept_dn;
  logic             w_accept_up;

  // Polarity is normalised after the second flop so the filter always sees 1 = pressed.
  assign w_pressed  = r_sync1 ^ KEY_ACTIVE_LOW;
  assign w_cnt_done = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_accept_dn = 1'b0;
    w_accept_up = 1'b0;
    case (r_state)
      ST_UP: begin
        if (w_pressed) begin
          w_state_nx = ST_WAIT_DN;
          w_cnt_nx   = CNT_ONE;
        end
      end
      ST_WAIT_DN: begin
        if (!w_pressed) begin
          w_state_nx = ST_UP;
          w_cnt_nx   = '0;
        end else if (w_cnt_done) begin
          w_state_nx  = ST_DN;
          w_cnt_nx    = '0;
          w_accept_dn = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      ST_DN: begin
        if (!w_pressed) begin
          w_state_nx = ST_WAIT_UP;
          w_cnt_nx   = CNT_ONE;
        end
      end
      ST_WAIT_UP: begin
        if (w_pressed) begin
          w_state_nx = ST_DN;
          w_cnt_nx   = '0;
        end else if (w_cnt_done) begin
          w_state_nx  = ST_UP;
          w_cnt_nx    = '0;
          w_accept_up = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nx = ST_UP;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync0   <= RELEASED;
      r_sync1   <= RELEASED;
      r_state   <= ST_UP;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_toggle  <= 1'b0;
    end else begin
      r_sync0   <= i_key_raw;
      r_sync1   <= r_sync0;
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_press   <= w_accept_dn;
      r_release <= w_accept_up;
      if (w_accept_dn) begin
        r_level  <= 1'b1;
        r_toggle <= ~r_toggle;
      end else if (w_accept_up) begin
        r_level <= 1'b0;
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_toggle  = r_toggle;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-key debouncer top, one independent channel per key
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 20 * CLK_PER_MS,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk50M,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_toggle
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_ch (
      .i_clk    (clk50M),
      .i_rst    (rst),
      .i_key_raw(key_raw[g]),
      .o_level  (key_level[g]),
      .o_press  (key_press[g]),
      .o_release(key_release[g]),
      .o_toggle (key_toggle[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce against a run-length reference model
module tb_key_debounce;

  localparam int NK = 2;
  localparam int D  = 8;

  logic          clk50M = 1'b0;
  logic          rst;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_toggle;

  typedef struct packed {
    logic [NK-1:0] level;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] toggle;
  } exp_t;

  exp_t sb[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   pulse_cnt = 0;

  always #5 clk50M = ~clk50M;

  key_debounce #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(D),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk50M     (clk50M),
    .rst        (rst),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_toggle (key_toggle)
  );

  // Reference: a new level is accepted once D consecutive synchronised samples,
  // all taken after the last acceptance, disagree with the current level.
  initial begin
    logic [NK-1:0] dly[2];
    logic [NK-1:0] ps;
    int            run[NK];
    exp_t          m;
    m      = '0;
    dly[0] = '0;
    dly[1] = '0;
    for (int i = 0; i < NK; i++) run[i] = 0;
    forever begin
      @(posedge clk50M);
      if (rst) begin
        m      = '0;
        dly[0] = '0;
        dly[1] = '0;
        for (int i = 0; i < NK; i++) run[i] = 0;
      end else begin
        ps      = dly[1];
        dly[1]  = dly[0];
        dly[0]  = ~key_raw;
        m.press = '0;
        m.rel   = '0;
        for (int i = 0; i < NK; i++) begin
          if (ps[i] != m.level[i]) begin
            run[i]++;
            if (run[i] == D) begin
              m.level[i] = ps[i];
              m.press[i] = ps[i];
              m.rel[i]   = ~ps[i];
              if (ps[i]) m.toggle[i] = ~m.toggle[i];
              run[i] = 0;
            end
          end else begin
            run[i] = 0;
          end
        end
      end
      sb.push_back(m);
    end
  end

  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(negedge clk50M);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g = '{level: key_level, press: key_press, rel: key_release, toggle: key_toggle};
        n_tests++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL sb t=%0t got lvl=%b prs=%b rel=%b tgl=%b exp lvl=%b prs=%b rel=%b tgl=%b",
                   $time, g.level, g.press, g.rel, g.toggle, e.level, e.press, e.rel, e.toggle);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk50M);
      #2;
      pulse_cnt += $countones({key_press, key_release});
    end
  endtask

  initial begin
    int hold[NK];
    rst     = 1'b1;
    key_raw = 2'b11;
    tick(3);
    check("rst_level", int'(key_level), 0);
    check("rst_pulses", int'({key_press, key_release}), 0);
    check("rst_toggle", int'(key_toggle), 0);
    rst       = 1'b0;
    pulse_cnt = 0;
    tick(50);
    check("idle_pulses", pulse_cnt, 0);

    key_raw[0] = 1'b0;
    tick(9);
    check("press_k8_level", int'(key_level[0]), 0);
    tick(1);
    check("press_k9_level", int'(key_level[0]), 1);
    check("press_k9_pulse", int'(key_press[0]), 1);
    check("press_key1", int'({key_level[1], key_press[1], key_toggle[1]}), 0);
    tick(1);
    check("press_k10_pulse", int'(key_press[0]), 0);
    check("press_toggle", int'(key_toggle[0]), 1);
    tick(5);

    key_raw[0] = 1'b1;
    tick(9);
    check("rel_m8_level", int'(key_level[0]), 1);
    tick(1);
    check("rel_m9_level", int'(key_level[0]), 0);
    check("rel_m9_pulse", int'(key_release[0]), 1);
    check("rel_toggle", int'(key_toggle[0]), 1);
    tick(1);
    check("rel_m10_pulse", int'(key_release[0]), 0);
    tick(5);

    pulse_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      key_raw[0] = (j % 2 == 0) ? 1'b0 : 1'b1;
      tick(3);
    end
    key_raw[0] = 1'b1;
    tick(15);
    check("bounce_pulses", pulse_cnt, 0);
    check("bounce_level", int'(key_level[0]), 0);

    key_raw[0] = 1'b0;
    tick(6);
    rst = 1'b1;
    tick(2);
    check("midrst_level", int'(key_level[0]), 0);
    rst = 1'b0;
    tick(9);
    check("midrst_r8_press", int'(key_press[0]), 0);
    tick(1);
    check("midrst_r9_press", int'(key_press[0]), 1);
    key_raw = 2'b11;
    tick(15);

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    key_raw = 2'b00;
    tick(10);
    check("simul_press", int'(key_press), 3);
    tick(1);
    check("simul_press_end", int'(key_press), 0);
    key_raw = 2'b11;
    tick(15);
    check("simul_released", int'(key_level), 0);
    key_raw[0] = 1'b0;
    tick(15);
    key_raw[0] = 1'b1;
    tick(15);
    check("simul_toggle", int'(key_toggle), 2);

    for (int i = 0; i < NK; i++) hold[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NK; i++) begin
        if (hold[i] == 0) begin
          key_raw[i] = 1'($urandom);
          hold[i]    = $urandom_range(1, 14);
        end else begin
          hold[i]--;
        end
      end
      rst = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);
    @(negedge clk50M);
    #1;
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
